// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: handshake and operand/result bus of the multi-cycle execute stage
interface ex_stage_mc_if #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic [RD_W-1:0] i_rd;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_res;
    logic [RD_W-1:0] o_rd;
    logic            o_busy;

    modport master (
        output i_valid, i_op, i_a, i_b, i_rd, i_flush, i_ready,
        input  o_ready, o_valid, o_res, o_rd, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_rd, i_flush, i_ready,
        output o_ready, o_valid, o_res, o_rd, o_busy
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: multi-cycle execute stage (add/sub, shift-add multiply, restoring divide)
// Optional EX_STAGE_MC_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module ex_stage_mc #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input logic          i_clk,
    input logic          i_rst,
    ex_stage_mc_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic              hi_q, hi_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              accept;
    logic              last;
    logic              mul_done;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     div_sh;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   quo_n;

    // acc holds the partial product (MUL) or partial remainder (DIV);
    // opa holds the shifting multiplicand or the divisor; opb the multiplier or dividend/quotient
    assign accept   = bus.i_valid && bus.o_ready && !bus.i_flush;
    assign last     = cnt_q == CW'(XLEN - 1);
    assign mul_acc  = opb_q[0] ? acc_q + opa_q : acc_q;
    assign div_sh   = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, opa_q[XLEN-1:0]};
    assign div_diff = div_sh[XLEN-1:0] - opa_q[XLEN-1:0];
    assign rem_n    = div_ge ? div_diff : div_sh[XLEN-1:0];
    assign quo_n    = {opb_q[XLEN-2:0], div_ge};
`ifdef EX_STAGE_MC_EARLY_OUT_EN
    assign mul_done = ~|opb_q[XLEN-1:1];
`else
    assign mul_done = last;
`endif

    assign bus.o_ready = state_q == IDLE || (state_q == DONE && bus.i_ready);
    assign bus.o_valid = state_q == DONE;
    assign bus.o_busy  = state_q == MUL || state_q == DIV;
    assign bus.o_res   = res_q;
    assign bus.o_rd    = rd_q;

    // next state and datapath: flush beats accept, accept beats iteration/drain
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        if (bus.i_flush) begin
            state_d = IDLE;
        end else if (accept) begin
            hi_d    = bus.i_op[0];
            rd_d    = bus.i_rd;
            acc_d   = '0;
            cnt_d   = '0;
            opa_d   = {{XLEN{1'b0}}, bus.i_op[2] ? bus.i_b : bus.i_a};
            opb_d   = bus.i_op[2] ? bus.i_a : bus.i_b;
            res_d   = bus.i_op == 3'b000 ? bus.i_a + bus.i_b :
                      bus.i_op == 3'b001 ? bus.i_a - bus.i_b : '0;
            state_d = bus.i_op[2:1] == 2'b01 ? MUL :
                      bus.i_op[2:1] == 2'b10 ? DIV : DONE;
        end else if (state_q == MUL) begin
            acc_d = mul_acc;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (mul_done) begin
                state_d = DONE;
                res_d   = hi_q ? mul_acc[2*XLEN-1:XLEN] : mul_acc[XLEN-1:0];
            end
        end else if (state_q == DIV) begin
            acc_d = {{XLEN{1'b0}}, rem_n};
            opb_d = quo_n;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                res_d   = hi_q ? rem_n : quo_n;
            end
        end else if (state_q == DONE && bus.i_ready) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            hi_q    <= 1'b0;
            rd_q    <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: scoreboard bench for ex_stage_mc at XLEN=32
module tb_ex_stage_mc;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [RD_W-1:0] rd;
        int              first;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_stage_mc_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    ex_stage_mc #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[XLEN-1:0];
            3'd3:    return p[2*XLEN-1:XLEN];
            3'd4:    return b == 0 ? '1 : a / b;
            3'd5:    return b == 0 ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [XLEN-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
        if (op[2:1] == 2'b01) begin
`ifdef EX_STAGE_MC_EARLY_OUT_EN
            return (n == 0 ? 1 : n) + 1;
`else
            return XLEN + 1;
`endif
        end
        if (op[2:1] == 2'b10) return XLEN + 1;
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.o_ready && t < 200) begin
            step();
            t++;
        end
        if (!bus.o_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd);
        exp_t e;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_rd    = rd;
        e.res   = model(op, a, b);
        e.rd    = rd;
        e.first = cyc + lat(op, b);
        q.push_back(e);
        step();
        bus.i_valid = 1'b0;
        bus.i_op    = 3'($urandom);
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        bus.i_rd    = RD_W'($urandom);
    endtask

    task automatic wait_drain(input int n);
        int t;
        t = 0;
        while (q.size() != 0 && t < n) begin
            step();
            t++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 64'(q.size()), 0);
            q.delete();
        end
    endtask

    // output monitor: compares every cycle o_valid is high, pops on handshake
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() == 0) seen = 1'b0;
            if (bus.o_busy) check("ready_busy", bus.o_ready, 0);
            if (bus.o_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    if (!seen) check("latency", 64'(cyc), 64'(q[0].first));
                    seen = 1'b1;
                    check("res", bus.o_res, q[0].res);
                    check("rd", bus.o_rd, q[0].rd);
                    if (bus.i_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0]      op;
        logic [XLEN-1:0] b;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_op    = '0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_rd    = '0;
        repeat (3) step();
        check("rst_valid", bus.o_valid, 0);
        check("rst_res", bus.o_res, 0);
        check("rst_rd", bus.o_rd, 0);
        check("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        step();
        check("rst_ready", bus.o_ready, 1);

        send(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd7);
        wait_drain(10);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        wait_drain(60);
        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_drain(60);
        send(3'd4, 32'd100, 32'd7, 5'd3);
        wait_drain(60);
        send(3'd5, 32'd100, 32'd7, 5'd4);
        wait_drain(60);
        send(3'd4, 32'd5, 32'd0, 5'd5);
        wait_drain(60);
        send(3'd5, 32'd5, 32'd0, 5'd6);
        wait_drain(60);
        send(3'd6, 32'd5, 32'd9, 5'd8);
        wait_drain(10);
        send(3'd2, 32'd9, 32'd3, 5'd10);
        wait_drain(60);
        send(3'd3, 32'd9, 32'd0, 5'd11);
        wait_drain(60);

        send(3'd4, 32'd100, 32'd7, 5'd9);
        bus.i_ready = 1'b0;
        for (int t = 0; t < 60 && !bus.o_valid; t++) step();
        check("hold_reached", bus.o_valid, 1);
        repeat (5) step();
        bus.i_ready = 1'b1;
        send(3'd0, 32'd2, 32'd3, 5'd12);
        wait_drain(10);

        for (int i = 0; i < 4; i++) send(3'(i % 2), $urandom, $urandom, RD_W'(i));
        wait_drain(10);

        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            b  = $urandom_range(0, 3) == 0 ? '0 : $urandom;
            wait_ready();
            send(op, $urandom, b, RD_W'($urandom));
        end
        wait_drain(100);

        send(3'd4, 32'd1000, 32'd3, 5'd13);
        repeat (9) step();
        q.delete();
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd0;
        step();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        check("flush_busy", bus.o_busy, 0);
        check("flush_valid", bus.o_valid, 0);
        check("flush_ready", bus.o_ready, 1);
        repeat (40) step();
        check("flush_quiet", bus.o_valid, 0);

        send(3'd2, 32'd12345, 32'd678, 5'd6);
        repeat (5) step();
        q.delete();
        rst = 1'b1;
        step();
        check("mrst_valid", bus.o_valid, 0);
        check("mrst_res", bus.o_res, 0);
        check("mrst_rd", bus.o_rd, 0);
        check("mrst_busy", bus.o_busy, 0);
        check("mrst_ready", bus.o_ready, 1);
        rst = 1'b0;
        repeat (40) step();
        send(3'd1, 32'd3, 32'd5, 5'd14);
        wait_drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
